// File: rtl/post_host.sv
// POST host: drives pulses on testreq to resync the remote postbox FSM and
// to read one byte from it with an INPUT command, wait-state polling and a timeout.
module post_host #(
  parameter int PWID_CYC  = 1,
  parameter int PGAP_CYC  = 1,
  parameter int BREAK_CYC = 50,
  parameter int MAX_WS    = 255
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       start,
  input  logic       sync,
  output logic       busy,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  output logic       timeout,
  output logic       testreq,
  input  logic       testack
);

  localparam int CW = 16;
  localparam logic [CW-1:0] PWID_M1  = CW'(PWID_CYC - 1);
  localparam logic [CW-1:0] PGAP_M1  = CW'(PGAP_CYC - 1);
  localparam logic [CW-1:0] BREAK_M1 = CW'(BREAK_CYC - 1);
  localparam logic [7:0]    WS_M1    = 8'(MAX_WS - 1);

  typedef enum logic [2:0] {
    ST_SYNC, ST_BREAK, ST_IDLE, ST_CMD, ST_WAIT, ST_DATA
  } state_t;

  typedef enum logic [1:0] {
    PH_START, PH_HI, PH_LO
  } phase_t;

  state_t          state;
  phase_t          phase;
  logic [CW-1:0]   cyc_cnt;
  logic [3:0]      pulse_idx;
  logic [7:0]      ws_cnt;
  logic            ack_smp;
  logic [7:0]      sr;

  logic            hi_end;
  logic            lo_end;
  logic            last_pulse;

  // Index of the final pulse each pulse-emitting state produces.
  function automatic logic [3:0] last_idx(input state_t s);
    case (s)
      ST_SYNC: last_idx = 4'd3;
      ST_CMD:  last_idx = 4'd3;
      ST_DATA: last_idx = 4'd7;
      default: last_idx = 4'd0;
    endcase
  endfunction

  assign hi_end     = (phase == PH_HI) && (cyc_cnt == PWID_M1);
  assign lo_end     = (phase == PH_LO) && (cyc_cnt == PGAP_M1);
  assign last_pulse = (pulse_idx == last_idx(state));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= ST_SYNC;
      phase     <= PH_START;
      cyc_cnt   <= '0;
      pulse_idx <= '0;
      ws_cnt    <= '0;
      ack_smp   <= 1'b0;
      sr        <= '0;
      rxdata    <= '0;
      rxvalid   <= 1'b0;
      timeout   <= 1'b0;
      testreq   <= 1'b0;
      busy      <= 1'b1;
    end else begin
      rxvalid <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync || start) begin
            state     <= sync ? ST_SYNC : ST_CMD;
            busy      <= 1'b1;
            testreq   <= 1'b1;
            phase     <= PH_HI;
            cyc_cnt   <= '0;
            pulse_idx <= '0;
            ws_cnt    <= '0;
          end
        end

        ST_BREAK: begin
          if (cyc_cnt == BREAK_M1) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          case (phase)
            PH_START: begin
              testreq <= 1'b1;
              phase   <= PH_HI;
              cyc_cnt <= '0;
            end

            PH_HI: begin
              if (hi_end) begin
                testreq <= 1'b0;
                phase   <= PH_LO;
                cyc_cnt <= '0;
                ack_smp <= testack;
                if (state == ST_DATA)
                  sr <= {sr[6:0], testack};
              end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
              end
            end

            PH_LO: begin
              if (!lo_end) begin
                cyc_cnt <= cyc_cnt + 1'b1;
              end else begin
                cyc_cnt <= '0;
                if (!last_pulse) begin
                  pulse_idx <= pulse_idx + 1'b1;
                  testreq   <= 1'b1;
                  phase     <= PH_HI;
                end else begin
                  pulse_idx <= '0;
                  phase     <= PH_HI;
                  case (state)
                    ST_CMD, ST_WAIT: begin
                      if (ack_smp) begin
                        state   <= ST_DATA;
                        testreq <= 1'b1;
                      end else if (state == ST_WAIT && ws_cnt == WS_M1) begin
                        // Compare before incrementing so the counter never wraps.
                        timeout <= 1'b1;
                        state   <= ST_BREAK;
                      end else begin
                        ws_cnt  <= (state == ST_WAIT) ? ws_cnt + 1'b1 : 8'd0;
                        state   <= ST_WAIT;
                        testreq <= 1'b1;
                      end
                    end
                    ST_DATA: begin
                      rxdata  <= sr;
                      rxvalid <= 1'b1;
                      state   <= ST_BREAK;
                    end
                    default: state <= ST_BREAK;
                  endcase
                end
              end
            end

            default: phase <= PH_START;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_post_host.sv
// Directed bench for post_host: a responder answers each testreq pulse from a
// per-transaction bit queue; a table of transactions is checked, then resync corners.
`timescale 1ns/1ps
module tb_post_host;

  logic       refclk = 1'b0;
  logic       rst;
  logic       start;
  logic       sync;
  logic       busy;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       timeout;
  logic       testreq;
  logic       testack;

  post_host #(
    .PWID_CYC (1),
    .PGAP_CYC (1),
    .BREAK_CYC(50),
    .MAX_WS   (4)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .start  (start),
    .sync   (sync),
    .busy   (busy),
    .rxdata (rxdata),
    .rxvalid(rxvalid),
    .timeout(timeout),
    .testreq(testreq),
    .testack(testack)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  int pulses    = 0;
  int low_run   = 0;
  int valid_cnt = 0;
  int to_cnt    = 0;
  bit prev_req  = 1'b0;
  bit ack_q[$];

  typedef struct {
    string      name;
    logic [3:0] cmd_ack;     // ack for CMD pulses 0..3
    int         n_nack;      // NACKed wait pulses
    bit         w_ack;       // ack a wait pulse after the NACKs
    logic [7:0] data;
    bit         extra_start; // poke start/sync while busy
    int         exp_pulses;
    logic [7:0] exp_rx;
    int         exp_valid;
    int         exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    pulses    = 0;
    low_run   = 0;
    valid_cnt = 0;
    to_cnt    = 0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(negedge refclk);
      #1;
      cyc++;
    end
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  // Responder and monitor, evaluated away from the active edge.
  initial begin
    testack = 1'b0;
    forever begin
      @(negedge refclk);
      if (testreq && !prev_req) begin
        pulses++;
        testack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
      end else if (!testreq) begin
        testack = 1'b0;
      end
      if (testreq) low_run = 0;
      else if (busy) low_run++;
      if (rxvalid) valid_cnt++;
      if (timeout) to_cnt++;
      prev_req = testreq;
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge refclk);
    #1;
    clear_counts();
    ack_q.delete();
    for (int i = 0; i < 4; i++) ack_q.push_back(v.cmd_ack[i]);
    if (!v.cmd_ack[3]) begin
      for (int i = 0; i < v.n_nack; i++) ack_q.push_back(1'b0);
      if (v.w_ack) ack_q.push_back(1'b1);
    end
    if (v.cmd_ack[3] || v.w_ack)
      for (int i = 7; i >= 0; i--) ack_q.push_back(v.data[i]);
    start = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    if (v.extra_start) begin
      repeat (5) @(negedge refclk);
      start = 1'b1;
      sync  = 1'b1;
      @(negedge refclk);
      start = 1'b0;
      sync  = 1'b0;
    end
    wait_idle(v.name);
    chk({v.name, "_pulses"}, pulses, v.exp_pulses);
    chk({v.name, "_rxdata"}, int'(rxdata), int'(v.exp_rx));
    chk({v.name, "_rxvalid"}, valid_cnt, v.exp_valid);
    chk({v.name, "_timeout"}, to_cnt, v.exp_to);
    chk({v.name, "_break"}, low_run, 51);
    $display("txn %-16s pulses=%0d rxdata=%02h rxvalid=%0d timeout=%0d break=%0d",
             v.name, pulses, rxdata, valid_cnt, to_cnt, low_run);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{"cmd_ack_a5",     4'b1000, 0, 1'b0, 8'hA5, 1'b0, 12, 8'hA5, 1, 0};
    vecs[1] = '{"wait2_5a",       4'b0000, 2, 1'b1, 8'h5A, 1'b1, 15, 8'h5A, 1, 0};
    vecs[2] = '{"timeout_ws4",    4'b0000, 4, 1'b0, 8'h00, 1'b0,  8, 8'h5A, 0, 1};
    vecs[3] = '{"noise_w1_3c",    4'b0111, 0, 1'b1, 8'h3C, 1'b0, 13, 8'h3C, 1, 0};
    vecs[4] = '{"ack_last_ws_00", 4'b0000, 3, 1'b1, 8'h00, 1'b0, 16, 8'h00, 1, 0};
    vecs[5] = '{"ack_ff",         4'b1000, 0, 1'b0, 8'hFF, 1'b0, 12, 8'hFF, 1, 0};

    rst   = 1'b1;
    start = 1'b0;
    sync  = 1'b0;
    repeat (3) @(negedge refclk);
    #1;
    chk("rst_testreq", int'(testreq), 0);
    chk("rst_busy",    int'(busy),    1);
    chk("rst_rxvalid", int'(rxvalid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_rxdata",  int'(rxdata),  0);
    clear_counts();
    @(negedge refclk);
    rst = 1'b0;
    wait_idle("post_rst");
    chk("post_rst_pulses",  pulses,    4);
    chk("post_rst_break",   low_run,   51);
    chk("post_rst_rxvalid", valid_cnt, 0);
    $display("txn %-16s pulses=%0d break=%0d", "post_rst", pulses, low_run);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start and sync together in IDLE: only a resync happens.
    @(negedge refclk);
    #1;
    clear_counts();
    ack_q.delete();
    for (int i = 0; i < 16; i++) ack_q.push_back(1'b1);
    start = 1'b1;
    sync  = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    sync  = 1'b0;
    wait_idle("sync_start");
    chk("sync_start_pulses",  pulses,       4);
    chk("sync_start_rxvalid", valid_cnt,    0);
    chk("sync_start_timeout", to_cnt,       0);
    chk("sync_start_rxdata",  int'(rxdata), 8'hFF);
    chk("sync_start_break",   low_run,      51);
    $display("txn %-16s pulses=%0d break=%0d", "sync_start", pulses, low_run);

    // Reset during the 5th DATA pulse (9th pulse overall).
    @(negedge refclk);
    #1;
    clear_counts();
    ack_q.delete();
    for (int i = 0; i < 3; i++) ack_q.push_back(1'b0);
    ack_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) ack_q.push_back(i[0]);
    start = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    cyc = 0;
    while (!(pulses == 9 && testreq) && cyc < 200) begin
      @(negedge refclk);
      #1;
      cyc++;
    end
    chk("midrst_reached", int'(pulses == 9 && testreq), 1);
    rst = 1'b1;
    #1;
    chk("midrst_testreq", int'(testreq), 0);
    chk("midrst_busy",    int'(busy),    1);
    chk("midrst_rxdata",  int'(rxdata),  0);
    @(negedge refclk);
    rst = 1'b0;
    #1;
    pulses  = 0;
    low_run = 0;
    ack_q.delete();
    wait_idle("midrst");
    chk("midrst_pulses",  pulses,       4);
    chk("midrst_rxvalid", valid_cnt,    0);
    chk("midrst_timeout", to_cnt,       0);
    chk("midrst_rxdata2", int'(rxdata), 0);
    chk("midrst_break",   low_run,      51);
    $display("txn %-16s pulses=%0d rxdata=%02h break=%0d", "midrst", pulses, rxdata, low_run);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/post_host.md
POST_HOST -- requirements
Module: post_host

Interface
REQ-001 Parameter PWID_CYC, default 1: testreq high time per pulse, in refclk cycles (>=1).
REQ-002 Parameter PGAP_CYC, default 1: testreq low time between pulses, in refclk cycles (>=1).
REQ-003 Parameter BREAK_CYC, default 50: break low time, in refclk cycles (25 us at 2 MHz).
REQ-004 Parameter MAX_WS, default 255: maximum NACKed wait-state pulses before timeout (1..255).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 refclk  in  1  2 MHz reference clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  single-cycle request to run one INPUT transaction.
REQ-009 sync  in  1  single-cycle request to resynchronise the remote FSM.
REQ-010 busy  out  1  high whenever the FSM is not IDLE.
REQ-011 rxdata  out  8  last received byte.
REQ-012 rxvalid  out  1  one-cycle strobe: rxdata updated.
REQ-013 timeout  out  1  one-cycle strobe: INPUT abandoned, no ACK within MAX_WS wait pulses.
REQ-014 testreq  out  1  POST request line to the postbox, registered output.
REQ-015 testack  in  1  POST acknowledge/data line from the postbox.

Function
REQ-016 A pulse is testreq high for PWID_CYC cycles, then low for PGAP_CYC cycles.
REQ-017 testack is sampled on the rising edge that ends a pulse's high phase (last cycle with testreq=1).
REQ-018 A break is testreq low for BREAK_CYC consecutive cycles, counted from the end of the preceding gap.
REQ-019 FSM states: SYNC, BREAK, IDLE, CMD, WAIT, DATA.
REQ-020 SYNC: emits 4 pulses, ignores testack, then goes to BREAK.
REQ-021 IDLE: testreq=0, busy=0. sync=1 goes to SYNC. Otherwise start=1 goes to CMD.
REQ-022 sync and start asserted in the same cycle: sync wins, start is dropped.
REQ-023 start or sync asserted while busy=1 is ignored and not queued.
REQ-024 CMD: emits 4 pulses (INPUT command).
REQ-025 CMD exit: testack=1 on the 4th pulse goes to DATA; testack=0 goes to WAIT.
REQ-026 WAIT: emits single pulses.
REQ-027 WAIT exit: the first pulse with testack=1 goes to DATA.
REQ-028 WAIT timeout: if MAX_WS consecutive wait pulses all sample 0, timeout pulses for 1 cycle and the FSM goes to BREAK.
REQ-029 DATA: emits exactly 8 pulses and shifts each sample into a shift register MSB-first (sr <= {sr[6:0], testack}).
REQ-030 DATA completion: on the cycle after the 8th pulse's gap ends, rxdata <= shift register and rxvalid=1 for one cycle; the FSM goes to BREAK.
REQ-031 BREAK: after BREAK_CYC low cycles, goes to IDLE; busy drops in the same cycle IDLE is entered.
REQ-032 rxvalid and timeout never assert in the same transaction; each is high for at most one cycle.
REQ-033 rxdata holds its value until the next successful transaction; a timeout does not modify it.
REQ-034 Wait-pulse counter is 8 bits and saturation-free: compare against MAX_WS before incrementing, so no wrap-around.

Reset
REQ-035 On rst=1, asynchronously: testreq=0, busy=1, rxvalid=0, timeout=0, rxdata=0x00, shift register and all counters cleared, state=SYNC.
REQ-036 On rst release, the FSM runs SYNC -> BREAK -> IDLE with no start needed.
REQ-037 rst asserted mid-transaction aborts it immediately; no rxvalid or timeout is issued for the aborted transfer.

Verification
REQ-038 Release rst with defaults -> 4 pulses (1 high/1 low each), then 50 low cycles, then busy=0; rxvalid never high.
REQ-039 Responder NACKs CMD and 2 wait pulses, ACKs the 3rd wait pulse, then sends 0x5A -> 4+3+8=15 pulses; rxdata=0x5A with a 1-cycle rxvalid; then a 50-cycle break.
REQ-040 Responder ACKs the 4th CMD pulse, then sends 0xA5 -> 12 pulses total; rxdata=0xA5; no wait pulses.
REQ-041 MAX_WS=4, testack held 0 -> 4 CMD + 4 wait pulses, 1-cycle timeout, rxdata unchanged, busy=0 after the break.
REQ-042 rst pulsed during the 5th DATA pulse -> testreq=0 in the same cycle, rxdata=0x00, no rxvalid, then a full resync sequence.
REQ-043 start during busy is ignored (pulse count unchanged); start+sync in the same IDLE cycle -> only 4 sync pulses plus a break, no INPUT.
